// File: rtl/jtag_debug_pkg.sv
// Shared definitions for the virtual-JTAG debug TAP.
//   ir_e         : 2-bit virtual instruction encoding
//   STATUS_WIDTH : width of the STATUS data register
package jtag_debug_pkg;

  localparam int unsigned STATUS_WIDTH = 8;

  typedef enum logic [1:0] {
    BYPASS = 2'b00,
    STATUS = 2'b01,
    WRITE  = 2'b10,
    READ   = 2'b11
  } ir_e;

endpackage

// File: rtl/jtag_cmd_holder.sv
// One-entry valid/ready command holding register with overflow detect.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_push        : request to load i_push_data
//   i_push_data   : command payload to store
//   i_ready       : downstream accepts the held command this cycle
//   o_data        : held command payload (stable while o_valid=1)
//   o_valid       : a command is held
//   o_drop        : push rejected because the entry is full and not draining
module jtag_cmd_holder #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_drop
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  w_accept;

  // A push is taken when the entry is empty or being drained in the same cycle.
  assign w_accept = i_push && (!r_valid || i_ready);
  assign o_drop   = i_push && r_valid && !i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= i_push_data;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/jtag_debug_tap.sv
// Virtual-JTAG debug TAP: IR-selected data registers bridging serial JTAG
// shifts to a parallel command/response interface.
// Ports:
//   clk, reset_n          : tck-domain clock, async-assert/sync-release reset
//   ir_in, ir_out         : virtual IR update value / IR capture value
//   tdi, tdo              : serial data in / out (tdo = LSB of selected DR)
//   state_cdr/sdr/udr/uir : virtual capture/shift/update DR and update IR
//   cmd_data, cmd_valid, cmd_ready : command stream to the debug bridge
//   rsp_data, rsp_valid, rsp_ready : response stream from the debug bridge
module jtag_debug_tap
  import jtag_debug_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            ir_in,
  input  logic                  tdi,
  input  logic                  state_cdr,
  input  logic                  state_sdr,
  input  logic                  state_udr,
  input  logic                  state_uir,
  output logic                  tdo,
  output logic [1:0]            ir_out,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_valid,
  output logic                  rsp_ready
);

  logic [1:0]              r_rst_sync;
  logic                    w_rst_n;
  ir_e                     r_ir;
  logic                    r_bypass;
  logic [STATUS_WIDTH-1:0] r_status;
  logic [DATA_WIDTH-1:0]   r_wr;
  logic [DATA_WIDTH:0]     r_rd;
  logic                    r_rsp_ready;
  logic                    r_overflow;
  logic                    r_underflow;
  logic                    w_push;
  logic                    w_drop;
  logic                    w_status_clr;
  logic                    w_underflow_set;
  logic                    w_cmd_valid;
  logic [DATA_WIDTH-1:0]   w_cmd_data;
  logic                    w_tdo;

  // Reset asserts immediately but releases two clk edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_push          = state_udr && (r_ir == WRITE);
  assign w_status_clr    = state_udr && (r_ir == STATUS);
  assign w_underflow_set = state_cdr && (r_ir == READ) && !rsp_valid;

  jtag_cmd_holder #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmd_holder (
    .clk         (clk),
    .rst_n       (w_rst_n),
    .i_push      (w_push),
    .i_push_data (r_wr),
    .i_ready     (cmd_ready),
    .o_data      (w_cmd_data),
    .o_valid     (w_cmd_valid),
    .o_drop      (w_drop)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ir        <= BYPASS;
      r_bypass    <= 1'b0;
      r_status    <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_rsp_ready <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (state_uir) r_ir <= ir_e'(ir_in);

      r_rsp_ready <= 1'b0;
      if (state_cdr) begin
        case (r_ir)
          BYPASS: r_bypass <= 1'b0;
          STATUS: r_status <= {{(STATUS_WIDTH-4){1'b0}}, r_overflow, r_underflow,
                               w_cmd_valid, rsp_valid};
          WRITE:  r_wr <= w_cmd_data;
          READ: begin
            r_rd        <= {rsp_valid, rsp_data};
            r_rsp_ready <= rsp_valid;
          end
        endcase
      end else if (state_sdr) begin
        case (r_ir)
          BYPASS: r_bypass <= tdi;
          STATUS: r_status <= {tdi, r_status[STATUS_WIDTH-1:1]};
          WRITE:  r_wr     <= {tdi, r_wr[DATA_WIDTH-1:1]};
          READ:   r_rd     <= {tdi, r_rd[DATA_WIDTH:1]};
        endcase
      end

      // Set events take priority over a STATUS update clear.
      if (w_drop)            r_overflow <= 1'b1;
      else if (w_status_clr) r_overflow <= 1'b0;

      if (w_underflow_set)   r_underflow <= 1'b1;
      else if (w_status_clr) r_underflow <= 1'b0;
    end
  end

  always_comb begin
    w_tdo = r_bypass;
    case (r_ir)
      BYPASS: w_tdo = r_bypass;
      STATUS: w_tdo = r_status[0];
      WRITE:  w_tdo = r_wr[0];
      READ:   w_tdo = r_rd[0];
    endcase
  end

  assign tdo       = w_tdo;
  assign ir_out    = {w_cmd_valid, rsp_valid};
  assign cmd_data  = w_cmd_data;
  assign cmd_valid = w_cmd_valid;
  assign rsp_ready = r_rsp_ready;

endmodule

// File: tb/tb_jtag_debug_tap.sv
// Directed self-checking bench for jtag_debug_tap (DATA_WIDTH=16).
module tb_jtag_debug_tap;

  logic        clk;
  logic        reset_n;
  logic [1:0]  ir_in;
  logic        tdi;
  logic        state_cdr, state_sdr, state_udr, state_uir;
  logic        tdo;
  logic [1:0]  ir_out;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;

  int total = 0;
  int bad   = 0;

  jtag_debug_tap #(.DATA_WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ir_in     (ir_in),
    .tdi       (tdi),
    .state_cdr (state_cdr),
    .state_sdr (state_sdr),
    .state_udr (state_udr),
    .state_uir (state_uir),
    .tdo       (tdo),
    .ir_out    (ir_out),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ir;
    int          n;
    logic [31:0] din;
    logic [31:0] exp_tdo;
    logic        exp_cv;
    logic [15:0] exp_data;
  } vec_t;

  vec_t        tbl[6];
  logic        d_tdo, d_rr;
  logic [31:0] dout, rrv;
  logic        seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Samples outputs at a negedge, then drives inputs for the following posedge.
  task automatic step(input logic cdr, input logic sdr, input logic udr, input logic uir,
                      input logic t, input logic rdy, output logic otdo, output logic orr);
    @(negedge clk);
    otdo = tdo;
    orr  = rsp_ready;
    state_cdr = cdr; state_sdr = sdr; state_udr = udr; state_uir = uir;
    tdi = t; cmd_ready = rdy;
  endtask

  task automatic idle(input int n);
    logic a, b;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, a, b);
  endtask

  task automatic set_ir(input logic [1:0] v);
    logic a, b;
    ir_in = v;
    step(0, 0, 0, 1, 0, 0, a, b);
  endtask

  task automatic capture();
    logic a, b;
    step(1, 0, 0, 0, 0, 0, a, b);
  endtask

  task automatic udr(input logic rdy);
    logic a, b;
    step(0, 0, 1, 0, 0, rdy, a, b);
  endtask

  task automatic shift(input int n, input logic [31:0] din,
                       output logic [31:0] o, output logic [31:0] rr);
    logic t, r;
    o = '0; rr = '0;
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 0, din[i], 0, t, r);
      o[i]  = t;
      rr[i] = r;
    end
  endtask

  task automatic read_status(output logic [31:0] o);
    logic [31:0] r;
    set_ir(2'b01);
    capture();
    shift(8, 32'h0, o, r);
  endtask

  initial begin
    reset_n = 1'b0; ir_in = 2'b00; tdi = 1'b0;
    state_cdr = 0; state_sdr = 0; state_udr = 0; state_uir = 0;
    cmd_ready = 0; rsp_data = '0; rsp_valid = 0;

    // Captured values: previous cmd_data for WRITE, 0 for BYPASS.
    tbl[0] = '{2'b10, 16, 32'h1234,  32'h0000,  1'b1, 16'h1234};
    tbl[1] = '{2'b10, 16, 32'hBEEF,  32'h1234,  1'b1, 16'hBEEF};
    tbl[2] = '{2'b10, 20, 32'hABCD5, 32'h5BEEF, 1'b1, 16'hABCD};
    tbl[3] = '{2'b10, 4,  32'h7,     32'hD,     1'b1, 16'h7ABC};
    tbl[4] = '{2'b10, 1,  32'h1,     32'h0,     1'b1, 16'hBD5E};
    tbl[5] = '{2'b00, 5,  32'h0D,    32'h1A,    1'b0, 16'hBD5E};

    repeat (3) @(negedge clk);
    check("rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check("rst_cmd_data",  {16'h0, cmd_data}, 32'h0);
    check("rst_rsp_ready", {31'h0, rsp_ready}, 32'h0);
    check("rst_tdo",       {31'h0, tdo}, 32'h0);
    check("rst_ir_out",    {30'h0, ir_out}, 32'h0);
    reset_n = 1'b1;
    idle(3);

    for (int v = 0; v < 6; v++) begin
      set_ir(tbl[v].ir);
      capture();
      shift(tbl[v].n, tbl[v].din, dout, rrv);
      udr(1'b0);
      idle(1);
      check($sformatf("vec%0d_tdo", v), dout, tbl[v].exp_tdo);
      check($sformatf("vec%0d_cmd_valid", v), {31'h0, cmd_valid}, {31'h0, tbl[v].exp_cv});
      check($sformatf("vec%0d_cmd_data", v), {16'h0, cmd_data}, {16'h0, tbl[v].exp_data});
      step(0, 0, 0, 0, 0, 1, d_tdo, d_rr);
      idle(1);
    end

    // Push with bridge stalled.
    set_ir(2'b10);
    capture();
    shift(16, 32'h1234, dout, rrv);
    udr(1'b0);
    idle(1);
    check("push_cmd_valid", {31'h0, cmd_valid}, 32'h1);
    check("push_cmd_data",  {16'h0, cmd_data}, 32'h1234);
    check("push_ir_out",    {30'h0, ir_out}, 32'h2);

    // Second push while full is dropped and flags overflow.
    capture();
    shift(16, 32'hBEEF, dout, rrv);
    udr(1'b0);
    idle(1);
    check("drop_cmd_data",  {16'h0, cmd_data}, 32'h1234);
    check("drop_cmd_valid", {31'h0, cmd_valid}, 32'h1);
    read_status(dout);
    check("status_overflow", dout, 32'h0A);   // overflow + pending command
    udr(1'b0);
    idle(1);
    capture();
    shift(8, 32'h0, dout, rrv);
    check("status_cleared", dout, 32'h02);

    // Push coincident with drain is accepted without overflow.
    set_ir(2'b10);
    capture();
    shift(16, 32'h0001, dout, rrv);
    udr(1'b1);
    idle(1);
    check("swap_cmd_data",  {16'h0, cmd_data}, 32'h0001);
    check("swap_cmd_valid", {31'h0, cmd_valid}, 32'h1);
    read_status(dout);
    check("swap_no_overflow", dout, 32'h02);
    step(0, 0, 0, 0, 0, 1, d_tdo, d_rr);
    idle(1);
    check("drain_cmd_valid", {31'h0, cmd_valid}, 32'h0);

    // READ with no response available: underflow.
    set_ir(2'b11);
    capture();
    shift(17, 32'h0, dout, rrv);
    check("underflow_tdo", dout, 32'h0);
    check("underflow_rsp_ready", rrv, 32'h0);
    read_status(dout);
    check("status_underflow", dout, 32'h04);
    udr(1'b0);
    idle(1);

    // READ with response available: data then valid bit, one-cycle rsp_ready.
    rsp_valid = 1'b1;
    rsp_data  = 16'hA5A5;
    idle(1);
    check("rsp_ir_out", {30'h0, ir_out}, 32'h1);
    set_ir(2'b11);
    capture();
    shift(17, 32'h0, dout, rrv);
    check("read_tdo", dout, 32'h1A5A5);
    check("read_rsp_ready_pulse", rrv, 32'h1);
    rsp_valid = 1'b0;
    read_status(dout);
    check("status_after_read", dout, 32'h00);

    // Reset mid-shift with a pending command.
    set_ir(2'b10);
    capture();
    shift(16, 32'h5555, dout, rrv);
    udr(1'b0);
    idle(1);
    check("pre_reset_cmd_valid", {31'h0, cmd_valid}, 32'h1);
    capture();
    shift(5, 32'h1F, dout, rrv);
    #2;
    reset_n = 1'b0;
    state_sdr = 0; state_cdr = 0; state_udr = 0; state_uir = 0;
    #1;
    check("mid_rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check("mid_rst_cmd_data",  {16'h0, cmd_data}, 32'h0);
    check("mid_rst_rsp_ready", {31'h0, rsp_ready}, 32'h0);
    check("mid_rst_tdo",       {31'h0, tdo}, 32'h0);
    check("mid_rst_ir_out",    {30'h0, ir_out}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 0, d_tdo, d_rr);
      seen = seen | cmd_valid | d_rr;
    end
    check("post_rst_no_pulse", {31'h0, seen}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
